// File: rtl/reg_file_param.sv
// Two-read, one-write register file that clears itself after reset; register 0 is hard-wired to zero.
// Latency: 1 cycle from read address to dout; INIT takes NREGS cycles after reset is released.
// Backpressure: none. ready is low during INIT and blocks writes; define REG_FILE_BYPASS_EN for write-through reads.
module reg_file_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_en,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] dout1,
  output logic [XLEN-1:0] dout2,
  input  logic            w_enable,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] din,
  output logic            ready
);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   init_cnt, init_cnt_nxt;
  logic            ready_nxt;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            wr_run;
  logic [XLEN-1:0] rd1_val, rd2_val;
  logic [XLEN-1:0] mem [NREGS];

  // A user write is accepted only in RUN and never to register 0.
  assign wr_run = (state == RUN) && w_enable && (waddr != '0);

  // Next-state logic. INIT sweeps one entry per cycle and hands over to RUN
  // on the same edge that clears the last entry.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    ready_nxt    = ready;
    mem_we       = 1'b0;
    mem_waddr    = waddr;
    mem_wdata    = din;
    case (state)
      INIT: begin
        mem_we       = 1'b1;
        mem_waddr    = init_cnt;
        mem_wdata    = '0;
        init_cnt_nxt = init_cnt + AW'(1);
        if (init_cnt == AW'(NREGS - 1)) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN: begin
        mem_we = wr_run;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Read data selection. Address 0 always returns zero, including when the
  // bypass path would otherwise forward din.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (raddr1 != '0) rd1_val = mem[raddr1];
    if (raddr2 != '0) rd2_val = mem[raddr2];
`ifdef REG_FILE_BYPASS_EN
    if (wr_run && (waddr == raddr1)) rd1_val = din;
    if (wr_run && (waddr == raddr2)) rd2_val = din;
`else
`endif
  end

  // Control state and registered read ports. Reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
      dout1    <= '0;
      dout2    <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      ready    <= ready_nxt;
      if (state == INIT) begin
        dout1 <= '0;
        dout2 <= '0;
      end else if (rd_en) begin
        dout1 <= rd1_val;
        dout2 <= rd2_val;
      end
    end
  end

  // Storage is not reset. The INIT sweep zeroes every entry before ready rises.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param at its default parameters, checked against an array-based reference model.
// The model advances once per clock edge and is driven by the current bench inputs.
// Honours REG_FILE_BYPASS_EN when it is defined for the build.
module tb_reg_file_param;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            rd_en = 1'b0;
  logic [AW-1:0]   raddr1 = '0, raddr2 = '0, waddr = '0;
  logic            w_enable = 1'b0;
  logic [XLEN-1:0] din = '0;
  logic [XLEN-1:0] dout1, dout2;
  logic            ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state.
  logic [XLEN-1:0] m_mem [NREGS];
  logic [XLEN-1:0] m_d1 = '0, m_d2 = '0;
  logic            m_ready = 1'b0;
  int              m_icnt = 0;

  reg_file_param #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
    .dout1(dout1), .dout2(dout2), .w_enable(w_enable), .waddr(waddr), .din(din),
    .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (w_enable && waddr != 0 && waddr == a) return din;
`endif
    return m_mem[a];
  endfunction

  // Advance the model by one edge using the current inputs, then move to posedge+1.
  task automatic tick();
    logic [XLEN-1:0] n1, n2;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_ready = 1'b0; m_icnt = 0;
    end else if (!m_ready) begin
      m_mem[m_icnt] = '0;
      m_icnt++;
      if (m_icnt == NREGS) m_ready = 1'b1;
      m_d1 = '0; m_d2 = '0;
    end else begin
      n1 = m_d1; n2 = m_d2;
      if (rd_en) begin n1 = m_read(raddr1); n2 = m_read(raddr2); end
      if (w_enable && waddr != 0) m_mem[waddr] = din;
      m_d1 = n1; m_d2 = n2;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; w_enable = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    idle(); w_enable = 1'b1; waddr = a; din = d; tick(); idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    idle(); rd_en = 1'b1; raddr1 = a1; raddr2 = a2; tick(); idle();
  endtask

  // Release reset and count edges until ready rises, with INIT traffic applied.
  task automatic run_init(input string tag);
    int edges;
    bit seen;
    reset = 1'b0; m_icnt = 0;
    edges = 0; seen = 0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      rd_en = 1'b1; w_enable = 1'b1; waddr = 5'd3; din = 32'hFF;
      raddr1 = AW'($urandom); raddr2 = AW'($urandom);
      tick();
      edges = k;
      if (ready) seen = 1;
      total_cnt++;
      if (dout1 !== '0 || dout2 !== '0)
        $display("FAIL %s_init_dout edge %0d: dout1=%h dout2=%h required 0", tag, k, dout1, dout2);
      else pass_cnt++;
    end
    idle();
    total_cnt++;
    if (!seen || edges != NREGS)
      $display("FAIL %s_init_len: ready after %0d edges (seen=%0d) required %0d", tag, edges, seen, NREGS);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total_cnt++;
    if (dout1 !== '0 || dout2 !== '0 || ready !== 1'b0)
      $display("FAIL reset_state: dout1=%h dout2=%h ready=%b required 0/0/0", dout1, dout2, ready);
    else pass_cnt++;
    tick(); tick();
    run_init("reset");
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd0);
    total_cnt++;
    if (dout1 !== 32'hDEADBEEF || dout2 !== 32'h0)
      $display("FAIL write_read: dout1=%h dout2=%h required deadbeef/0", dout1, dout2);
    else pass_cnt++;
  endtask

  task automatic test_addr0();
    do_write(5'd0, 32'h12345678);
    do_read(5'd0, 5'd3);
    total_cnt++;
    if (dout1 !== 32'h0) $display("FAIL addr0_read: dout1=%h required 0", dout1);
    else pass_cnt++;
    total_cnt++;
    if (dout2 !== 32'h0) $display("FAIL init_write_ignored: dout2=%h required 0", dout2);
    else pass_cnt++;
  endtask

  task automatic test_same_edge();
    logic [XLEN-1:0] exp_now;
`ifdef REG_FILE_BYPASS_EN
    exp_now = 32'h22222222;
`else
    exp_now = 32'h11111111;
`endif
    do_write(5'd7, 32'h11111111);
    rd_en = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    w_enable = 1'b1; waddr = 5'd7; din = 32'h22222222;
    tick(); idle();
    total_cnt++;
    if (dout1 !== exp_now || dout2 !== exp_now)
      $display("FAIL same_edge: dout1=%h dout2=%h required %h", dout1, dout2, exp_now);
    else pass_cnt++;
    do_read(5'd7, 5'd0);
    total_cnt++;
    if (dout1 !== 32'h22222222 || dout2 !== 32'h0)
      $display("FAIL same_edge_next: dout1=%h dout2=%h required 22222222/0", dout1, dout2);
    else pass_cnt++;
    // Bypass must never apply to register 0.
    rd_en = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
    w_enable = 1'b1; waddr = 5'd0; din = 32'hCAFEF00D;
    tick(); idle();
    total_cnt++;
    if (dout1 !== 32'h0 || dout2 !== 32'h0)
      $display("FAIL same_edge_addr0: dout1=%h dout2=%h required 0", dout1, dout2);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    do_write(5'd9, 32'hA5A5A5A5);
    do_read(5'd9, 5'd9);
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b0; raddr1 = AW'(k + 10); raddr2 = AW'(k + 1);
      w_enable = 1'b1; waddr = 5'd9; din = 32'h5A5A0000 + k;
      tick();
      total_cnt++;
      if (dout1 !== 32'hA5A5A5A5 || dout2 !== 32'hA5A5A5A5)
        $display("FAIL hold_%0d: dout1=%h dout2=%h required a5a5a5a5", k, dout1, dout2);
      else pass_cnt++;
    end
    do_read(5'd9, 5'd0);
    total_cnt++;
    if (dout1 !== 32'h5A5A0003) $display("FAIL hold_release: dout1=%h required 5a5a0003", dout1);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rd_en    = ($urandom_range(0, 3) != 0);
      w_enable = $urandom_range(0, 1) == 1;
      raddr1   = AW'($urandom);
      raddr2   = ($urandom_range(0, 4) == 0) ? raddr1 : AW'($urandom);
      waddr    = ($urandom_range(0, 2) == 0) ? raddr1 : AW'($urandom);
      din      = $urandom;
      tick();
      total_cnt++;
      if (dout1 !== m_d1 || dout2 !== m_d2 || ready !== m_ready)
        $display("FAIL random_%0d: dout1=%h dout2=%h ready=%b required %h/%h/%b",
                 k, dout1, dout2, ready, m_d1, m_d2, m_ready);
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    do_write(5'd5, 32'h0BADF00D);
    do_read(5'd5, 5'd5);
    reset = 1'b1;
    m_d1 = '0; m_d2 = '0; m_ready = 1'b0; m_icnt = 0;
    #2;
    total_cnt++;
    if (dout1 !== '0 || dout2 !== '0 || ready !== 1'b0)
      $display("FAIL midrun_reset: dout1=%h dout2=%h ready=%b required 0/0/0", dout1, dout2, ready);
    else pass_cnt++;
    @(posedge clk); #1;
    tick();
    run_init("midrun");
    do_read(5'd5, 5'd7);
    total_cnt++;
    if (dout1 !== '0 || dout2 !== '0)
      $display("FAIL midrun_cleared: dout1=%h dout2=%h required 0", dout1, dout2);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    #1;
    test_reset();
    test_write_read();
    test_addr0();
    test_same_edge();
    test_hold();
    test_random();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits (legal 8..64).
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of two, 2..64).
REQ-003 SHALL derive local parameter AW = log2(NREGS), meaning address width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_en  input  1  read-port update enable; low holds both outputs.
REQ-007 SHALL have port raddr1  input  AW  read address, port 1.
REQ-008 SHALL have port raddr2  input  AW  read address, port 2.
REQ-009 SHALL have port dout1  output  XLEN  registered read data, port 1.
REQ-010 SHALL have port dout2  output  XLEN  registered read data, port 2.
REQ-011 SHALL have port w_enable  input  1  write request.
REQ-012 SHALL have port waddr  input  AW  write address.
REQ-013 SHALL have port din  input  XLEN  write data.
REQ-014 SHALL have port ready  output  1  high once initialisation completes; writes and reads accepted only while high.

Function
REQ-015 SHALL implement a two-state FSM, INIT and RUN; reset forces INIT.
REQ-016 In INIT, SHALL write zero to one entry per cycle via a counter starting at 0, then go to RUN on the cycle after entry NREGS-1 is cleared; INIT lasts exactly NREGS cycles.
REQ-017 ready SHALL be 0 in INIT and 1 in RUN; it is registered and rises on the edge that enters RUN.
REQ-018 In INIT, SHALL ignore w_enable and hold dout1/dout2 at zero regardless of rd_en.
REQ-019 In RUN with rd_en=1, SHALL load dout1/dout2 from raddr1/raddr2 at the rising edge; read latency is one cycle.
REQ-020 In RUN with rd_en=0, dout1/dout2 SHALL hold their previous values.
REQ-021 Reads of address 0 SHALL always return zero.
REQ-022 In RUN, a write SHALL occur at the rising edge when w_enable=1 and waddr!=0; writes to address 0 SHALL be discarded.
REQ-023 When rd_en=1 and w_enable=1 at the same edge with raddrN==waddr!=0, doutN SHALL follow REQ-040/REQ-041.
REQ-024 Both read ports SHALL be independent; raddr1==raddr2 SHALL return identical data on both.
REQ-025 A write and a read to different addresses at the same edge SHALL not interfere.
REQ-026 The storage array SHALL be exactly NREGS x XLEN bits; no unused or extra bit per entry.

Reset
REQ-027 Asserting reset SHALL, without waiting for clk, set dout1=0, dout2=0, ready=0, state=INIT, init counter=0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL abort any operation; a full NREGS-cycle INIT restarts after deassertion.
REQ-029 Storage contents need not be cleared asynchronously; INIT guarantees all entries are zero before ready=1.
REQ-030 The first rising edge with reset low SHALL perform INIT clear of entry 0.

Configuration
REQ-040 With macro REG_FILE_BYPASS_EN defined, a same-edge read of an address being written SHALL return din (write-through forwarding), per port independently.
REQ-041 Without REG_FILE_BYPASS_EN, a same-edge read of an address being written SHALL return the pre-write value; the new value is visible on the next read.
REQ-042 Address 0 SHALL read as zero in both configurations, including when bypass conditions match.

Verification
REQ-050 Reset pulse, then release; count cycles -> ready rises exactly 32 edges after release (defaults); dout1/dout2 = 0 throughout.
REQ-051 After ready: write 0xDEADBEEF to r5, then read raddr1=5, raddr2=0 -> next cycle dout1=0xDEADBEEF, dout2=0.
REQ-052 Write 0x12345678 to r0, read r0 -> dout1=0; write during INIT (w_enable=1, waddr=3, din=0xFF) then read r3 after ready -> 0.
REQ-053 r7=0x11111111; same edge write r7=0x22222222 and read r7 -> dout1=0x22222222 with REG_FILE_BYPASS_EN, 0x11111111 without; following read 0x22222222 in both.
REQ-054 dout1=0xA5A5A5A5 displayed; drop rd_en, change raddr1 and write -> dout1 stays 0xA5A5A5A5 until rd_en=1.
REQ-055 Assert reset mid-RUN between clock edges -> dout1, dout2, ready = 0 immediately; after release previously written r5 reads 0 once ready.
